// File: rtl/uart_tx_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_tx_buf
//  Purpose  : UART transmitter fed by a small show-ahead byte FIFO.
//             Frames are 1 start bit, 8 data bits LSB first, 1 stop bit,
//             no parity, each bit held BAUD_END clocks.
//  Ports    : sclk      - system clock, rising edge
//             s_rst_n   - synchronous active-low reset
//             pi_data   - byte to transmit, sampled while pi_flag=1
//             pi_flag   - write strobe, one byte per high cycle
//             fifo_full - FIFO holds 2**FIFO_AW bytes
//             overflow  - 1-cycle pulse when a write is dropped
//             rs232_tx  - registered serial line, idles high
//             tx_busy   - frame in progress or bytes still buffered
//             tx_done   - 1-cycle pulse at the end of each stop bit
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_buf #(
  parameter int BAUD_END = 56,
  parameter int FIFO_AW  = 2
) (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic       fifo_full,
  output logic       overflow,
  output logic       rs232_tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam int BW    = (BAUD_END > 1) ? $clog2(BAUD_END) : 1;

  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_END - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // FIFO
  // --------------------------------------------------------------------------
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q,  count_d;

  state_t             state_q;
  logic               wr_en;
  logic               pop;

  // Acceptance is judged on the pre-edge count, so a pop in the same cycle
  // never makes room for that cycle's write.
  assign fifo_full = (count_q == DEPTH_CNT);
  assign wr_en     = pi_flag && !fifo_full;
  assign pop       = (state_q == ST_IDLE) && (count_q != '0);
  assign tx_busy   = (state_q != ST_IDLE) || (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    end
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: cleared pointers make stale entries unreachable.
  always_ff @(posedge sclk) begin
    if (s_rst_n && wr_en) begin
      mem_q[wr_ptr_q] <= pi_data;
    end
  end

  // --------------------------------------------------------------------------
  // Transmit FSM
  // --------------------------------------------------------------------------
  logic [BW-1:0] baud_cnt_q;
  logic [3:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          done_q;
  logic          ovf_q;

  // bit_cnt_q numbers the bit currently on the line: 0 = start, 1..8 = data,
  // 9 = stop. The value driven at a bit boundary is the one for bit_cnt_q+1.
  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ovf_q  <= pi_flag && fifo_full;
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q    <= mem_q[rd_ptr_q];
            tx_q       <= 1'b0;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            state_q    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (baud_cnt_q == BAUD_LAST) begin
            baud_cnt_q <= '0;
            if (bit_cnt_q == 4'd9) begin
              bit_cnt_q <= '0;
              done_q    <= 1'b1;
              tx_q      <= 1'b1;
              state_q   <= ST_IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              tx_q      <= (bit_cnt_q == 4'd8) ? 1'b1 : shift_q[bit_cnt_q[2:0]];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + BW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign rs232_tx = tx_q;
  assign tx_done  = done_q;
  assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_buf
//  Purpose  : Randomised scoreboard bench for uart_tx_buf. A behavioural
//             model tracks buffered bytes and frame timing; a serial-line
//             decoder pops expected bytes and compares whole frames.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buf;

  localparam int B     = 56;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * B;

  logic       sclk    = 1'b0;
  logic       s_rst_n = 1'b0;
  logic [7:0] pi_data = 8'h00;
  logic       pi_flag = 1'b0;
  logic       fifo_full;
  logic       overflow;
  logic       rs232_tx;
  logic       tx_busy;
  logic       tx_done;

  always #5 sclk = ~sclk;

  uart_tx_buf #(
    .BAUD_END (B),
    .FIFO_AW  (2)
  ) dut (
    .sclk      (sclk),
    .s_rst_n   (s_rst_n),
    .pi_data   (pi_data),
    .pi_flag   (pi_flag),
    .fifo_full (fifo_full),
    .overflow  (overflow),
    .rs232_tx  (rs232_tx),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  int checks   = 0;
  int failures = 0;

  // --------------------------------------------------------------------------
  // Reference model: bytes waiting, and the remaining clocks of the frame
  // currently on the line (0 = line idle).
  // --------------------------------------------------------------------------
  logic [7:0] m_fifo[$];
  logic [7:0] exp_q[$];
  int         m_rem     = 0;
  logic [9:0] m_frame   = 10'h3FF;
  logic       m_done    = 1'b0;
  logic       m_ovf     = 1'b0;
  logic       started   = 1'b0;
  int         rst_seen  = 0;

  always @(posedge sclk) begin
    logic       do_pop;
    logic       do_acc;
    logic [7:0] b;
    if (!s_rst_n) begin
      m_fifo.delete();
      exp_q.delete();
      m_rem   = 0;
      m_done  = 1'b0;
      m_ovf   = 1'b0;
      m_frame = 10'h3FF;
      started = 1'b1;
      rst_seen++;
    end else begin
      do_pop = (m_rem == 0) && (m_fifo.size() != 0);
      do_acc = pi_flag && (m_fifo.size() < DEPTH);
      m_ovf  = pi_flag && !do_acc;
      m_done = (m_rem == 1);
      if (do_pop) begin
        b       = m_fifo.pop_front();
        m_frame = {1'b1, b, 1'b0};
        m_rem   = FRAME;
      end else if (m_rem > 0) begin
        m_rem--;
      end
      if (do_acc) begin
        m_fifo.push_back(pi_data);
        exp_q.push_back(pi_data);
      end
    end
  end

  function automatic logic exp_line();
    int idx;
    if (m_rem == 0) return 1'b1;
    idx = (FRAME - m_rem) / B;
    return m_frame[idx];
  endfunction

  // --------------------------------------------------------------------------
  // Per-cycle output check and serial-line decoder (monitor)
  // --------------------------------------------------------------------------
  logic       mon_act  = 1'b0;
  int         mon_t    = 0;
  int         mon_rst  = 0;
  logic [9:0] mon_bits = '0;

  always @(negedge sclk) begin
    logic [4:0] got;
    logic [4:0] want;
    logic [7:0] e;
    int         k;
    if (started) begin
      got  = {rs232_tx, tx_done, tx_busy, fifo_full, overflow};
      want = {exp_line(), m_done, (m_rem != 0) || (m_fifo.size() != 0),
              (m_fifo.size() == DEPTH), m_ovf};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL outputs t=%0t tx/done/busy/full/ovf got=%b want=%b", $time, got, want);
      end

      if (mon_rst != rst_seen) begin
        mon_rst = rst_seen;
        mon_act = 1'b0;
      end else begin
        if (!mon_act && rs232_tx === 1'b0) begin
          mon_act = 1'b1;
          mon_t   = 0;
        end
        if (mon_act) begin
          if (mon_t >= B / 2 && ((mon_t - B / 2) % B) == 0) begin
            k = (mon_t - B / 2) / B;
            mon_bits[k] = rs232_tx;
            if (k == 9) begin
              mon_act = 1'b0;
              checks++;
              if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL frame t=%0t unexpected frame data=%h", $time, mon_bits[8:1]);
              end else begin
                e = exp_q.pop_front();
                if (mon_bits[8:1] !== e || mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) begin
                  failures++;
                  $display("FAIL frame t=%0t got start/data/stop=%b/%h/%b want 0/%h/1",
                           $time, mon_bits[0], mon_bits[8:1], mon_bits[9], e);
                end
              end
            end
          end
          mon_t++;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic drive(input logic f, input logic [7:0] d);
    @(negedge sclk);
    pi_flag = f;
    pi_data = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom));
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    drive(1'b0, 8'($urandom));
    while (tx_busy && n < maxc) begin
      drive(1'b0, 8'($urandom));
      n++;
    end
    if (tx_busy) begin
      checks++;
      failures++;
      $display("FAIL wait_idle tx_busy still %b after %0d clks, want 0", tx_busy, maxc);
    end
  endtask

  initial begin
    logic [7:0] lb [4];
    lb[0] = 8'hA5; lb[1] = 8'h3C; lb[2] = 8'hFF; lb[3] = 8'h00;

    // Reset, then idle 1000 ns
    repeat (5) @(negedge sclk);
    s_rst_n = 1'b1;
    idle(100);

    // Single byte
    drive(1'b1, 8'h55);
    wait_idle(2 * FRAME);
    idle(10);

    // Back-to-back burst
    for (int i = 0; i < 4; i++) drive(1'b1, lb[i]);
    wait_idle(6 * FRAME);
    idle(10);

    // Overflow: six consecutive writes, sixth dropped
    for (int i = 1; i <= 6; i++) drive(1'b1, 8'(i));
    wait_idle(7 * FRAME);
    idle(10);

    // Pointer wrap: three bursts of three
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) drive(1'b1, 8'($urandom));
      wait_idle(5 * FRAME);
    end
    idle(10);

    // Reset during data bit 4
    drive(1'b1, 8'h00);
    idle(1 + 4 * B + 10);
    @(negedge sclk);
    pi_flag = 1'b0;
    s_rst_n = 1'b0;
    @(negedge sclk);
    s_rst_n = 1'b1;
    idle(20);
    drive(1'b1, 8'h81);
    wait_idle(2 * FRAME);
    idle(10);

    // Randomised bursts and gaps
    for (int r = 0; r < 30; r++) begin
      int len;
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) drive($urandom_range(0, 3) != 0, 8'($urandom));
      idle($urandom_range(0, 1200));
    end
    wait_idle(8 * FRAME);
    idle(20);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending_bytes=%0d want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
